// File: rtl/dac_write_sequencer.sv
// DAC write sequencer: feeds a 16-bit code to the SPI master as MSB then LSB under one CS frame.
// Frames are started by explicit writes or by a periodic auto-refresh of the last accepted code.
module dac_write_sequencer #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int ACK_TIMEOUT    = 1023
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [15:0] i_DAC_Val,
  input  logic        i_DAC_Wr,
  input  logic        i_Auto_En,
  input  logic        i_TX_Ready,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  output logic [1:0]  o_TX_Count,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err
);

  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_MSB, ACK_MSB, WAIT_MSB, SEND_LSB, ACK_LSB, WAIT_LSB, DONE
  } state_t;

  state_t            r_State;
  state_t            w_Next;
  logic [15:0]       r_Shadow;
  logic [7:0]        r_FrameLsb;
  logic [7:0]        r_TX_Byte;
  logic              r_Pending;
  logic              r_Err;
  logic [REF_W-1:0]  r_RefCnt;
  logic [TO_W-1:0]   r_AckCnt;
  logic              w_Wrap;
  logic              w_Launch;
  logic              w_LoadLsb;
  logic              w_Timeout;
  logic              w_InAck;

  assign w_Wrap     = i_Auto_En && (r_RefCnt == REF_LAST);
  assign w_InAck    = (r_State == ACK_MSB) || (r_State == ACK_LSB);
  assign o_TX_Count = 2'd2;
  assign o_TX_Byte  = r_TX_Byte;
  assign o_Busy     = (r_State != IDLE);
  assign o_Err      = r_Err;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_State <= IDLE;
    else          r_State <= w_Next;
  end

  // DV is additionally gated by ready so a pulse can never reach a busy master.
  always_comb begin
    w_Next    = r_State;
    o_TX_DV   = 1'b0;
    o_Done    = 1'b0;
    w_Launch  = 1'b0;
    w_LoadLsb = 1'b0;
    w_Timeout = 1'b0;
    case (r_State)
      IDLE: if (r_Pending && i_TX_Ready) begin
        w_Launch = 1'b1;
        w_Next   = SEND_MSB;
      end
      SEND_MSB: if (i_TX_Ready) begin
        o_TX_DV = 1'b1;
        w_Next  = ACK_MSB;
      end
      ACK_MSB: begin
        if (!i_TX_Ready) w_Next = WAIT_MSB;
        else if (r_AckCnt == TO_LAST) begin
          w_Timeout = 1'b1;
          w_Next    = IDLE;
        end
      end
      WAIT_MSB: if (i_TX_Ready) begin
        w_LoadLsb = 1'b1;
        w_Next    = SEND_LSB;
      end
      SEND_LSB: if (i_TX_Ready) begin
        o_TX_DV = 1'b1;
        w_Next  = ACK_LSB;
      end
      ACK_LSB: begin
        if (!i_TX_Ready) w_Next = WAIT_LSB;
        else if (r_AckCnt == TO_LAST) begin
          w_Timeout = 1'b1;
          w_Next    = IDLE;
        end
      end
      WAIT_LSB: if (i_TX_Ready) w_Next = DONE;
      DONE: begin
        o_Done = 1'b1;
        w_Next = IDLE;
      end
      default: w_Next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Shadow  <= 16'h0000;
      r_Pending <= 1'b0;
      r_Err     <= 1'b0;
    end else begin
      if (i_DAC_Wr) r_Shadow <= i_DAC_Val;
      // A write or wrap on the launch cycle re-arms pending for one extra frame.
      r_Pending <= i_DAC_Wr | w_Wrap | (r_Pending & ~w_Launch);
      if (w_Timeout)     r_Err <= 1'b1;
      else if (i_DAC_Wr) r_Err <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_TX_Byte  <= 8'h00;
      r_FrameLsb <= 8'h00;
    end else if (w_Launch) begin
      r_TX_Byte  <= r_Shadow[15:8];
      r_FrameLsb <= r_Shadow[7:0];
    end else if (w_LoadLsb) begin
      r_TX_Byte  <= r_FrameLsb;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                       r_RefCnt <= '0;
    else if (!i_Auto_En || w_Wrap)      r_RefCnt <= '0;
    else                                r_RefCnt <= r_RefCnt + REF_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)     r_AckCnt <= '0;
    else if (w_InAck) r_AckCnt <= r_AckCnt + TO_W'(1);
    else              r_AckCnt <= '0;
  end

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Bench for dac_write_sequencer: SPI master model, table-driven single writes, hand-written
// corner sequences and a randomized run checked against a transaction-level model.
module tb_dac_write_sequencer;

  localparam int REFRESH = 100;
  localparam int ACKTO   = 8;

  typedef struct {
    logic [15:0] val;
    logic [7:0]  expMsb;
    logic [7:0]  expLsb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [15:0] dacVal;
  logic        dacWr;
  logic        autoEn;
  logic        txReady;
  logic [7:0]  txByte;
  logic        txDv;
  logic [1:0]  txCount;
  logic        busy;
  logic        done;
  logic        err;

  int   tests = 0;
  int   failed = 0;
  logic stuck;
  int   spiDelay;
  int   busyCnt;
  int   dvBad = 0;
  logic prevReady = 1'b1;

  time         dvTimes[$];
  logic [7:0]  dvBytes[$];
  time         doneTimes[$];
  time         riseTimes[$];
  time         wrTimes[$];
  logic [15:0] wrVals[$];

  vec_t        vec[5];
  time         wTime;
  time         launch;
  time         prevLaunch;
  logic [15:0] expCode;
  logic        fresh;
  int          nFrames;

  always #5 clk = ~clk;

  dac_write_sequencer #(.REFRESH_CYCLES(REFRESH), .ACK_TIMEOUT(ACKTO)) dut (
    .i_Clk(clk), .i_Rst_L(rstN), .i_DAC_Val(dacVal), .i_DAC_Wr(dacWr),
    .i_Auto_En(autoEn), .i_TX_Ready(txReady), .o_TX_Byte(txByte), .o_TX_DV(txDv),
    .o_TX_Count(txCount), .o_Busy(busy), .o_Done(done), .o_Err(err)
  );

  // SPI master: ready drops the cycle after an accepted DV and returns spiDelay cycles later.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txReady <= 1'b1;
      busyCnt <= 0;
    end else if (txReady) begin
      if (txDv && !stuck) begin
        txReady <= 1'b0;
        busyCnt <= spiDelay;
      end
    end else if (busyCnt <= 1) txReady <= 1'b1;
    else busyCnt <= busyCnt - 1;
  end

  always @(negedge clk) begin
    if (txDv) begin
      dvTimes.push_back($time);
      dvBytes.push_back(txByte);
      if (!txReady) dvBad++;
    end
    if (done) doneTimes.push_back($time);
    if (txReady && !prevReady) riseTimes.push_back($time);
    prevReady = txReady;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; the write is sampled on the following posedge.
  task automatic applyStimulus(input logic [15:0] val);
    dacVal = val;
    dacWr  = 1'b1;
    @(posedge clk);
    wrTimes.push_back($time);
    wrVals.push_back(val);
    #1 dacWr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitEvents(input int nDv, input int nDone, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dvTimes.size() >= nDv && doneTimes.size() >= nDone) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearLogs();
    dvTimes.delete();
    dvBytes.delete();
    doneTimes.delete();
    riseTimes.delete();
  endtask

  function automatic time riseAfter(input time t);
    time r;
    r = 0;
    foreach (riseTimes[i]) if (riseTimes[i] > t && r == 0) r = riseTimes[i];
    return r;
  endfunction

  initial begin
    dacVal = 16'h0000; dacWr = 1'b0; autoEn = 1'b0; stuck = 1'b0; spiDelay = 16;
    vec[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vec[1] = '{16'h0000, 8'h00, 8'h00};
    vec[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vec[3] = '{16'h8001, 8'h80, 8'h01};
    vec[4] = '{16'h7E81, 8'h7E, 8'h81};

    repeat (3) @(negedge clk);
    checkOutput("rst_byte",  txByte,  8'h00);
    checkOutput("rst_dv",    txDv,    1'b0);
    checkOutput("rst_busy",  busy,    1'b0);
    checkOutput("rst_done",  done,    1'b0);
    checkOutput("rst_err",   err,     1'b0);
    checkOutput("rst_count", txCount, 2'd2);
    @(posedge clk);
    #1 rstN = 1'b1;
    idle(3);

    for (int i = 0; i < 5; i++) begin
      clearLogs();
      applyStimulus(vec[i].val);
      wTime = wrTimes[$];
      waitEvents(2, 1, 200);
      checkOutput("tbl_dv_cnt", dvTimes.size(), 2);
      checkOutput("tbl_done_cnt", doneTimes.size(), 1);
      if (dvTimes.size() >= 2 && doneTimes.size() >= 1) begin
        checkOutput("tbl_msb", dvBytes[0], vec[i].expMsb);
        checkOutput("tbl_lsb", dvBytes[1], vec[i].expLsb);
        checkOutput("tbl_latency", dvTimes[0] - wTime, 15);
        checkOutput("tbl_done_time", doneTimes[0], riseAfter(dvTimes[1]) + 10);
      end
      idle(2);
      checkOutput("tbl_busy_after", busy, 1'b0);
      checkOutput("tbl_byte_hold", txByte, vec[i].expLsb);
      checkOutput("tbl_err", err, 1'b0);
    end

    clearLogs();
    applyStimulus(16'h1234);
    waitEvents(1, 0, 20);
    idle(5);
    applyStimulus(16'hBEEF);
    waitEvents(4, 2, 300);
    checkOutput("mid_dv_cnt", dvTimes.size(), 4);
    checkOutput("mid_done_cnt", doneTimes.size(), 2);
    if (dvTimes.size() >= 4 && doneTimes.size() >= 1) begin
      checkOutput("mid_b0", dvBytes[0], 8'h12);
      checkOutput("mid_b1", dvBytes[1], 8'h34);
      checkOutput("mid_b2", dvBytes[2], 8'hBE);
      checkOutput("mid_b3", dvBytes[3], 8'hEF);
      checkOutput("mid_restart", dvTimes[2], doneTimes[0] + 20);
    end

    clearLogs();
    applyStimulus(16'h0001);
    waitEvents(1, 0, 20);
    idle(3);
    applyStimulus(16'h0002);
    idle(2);
    applyStimulus(16'h0003);
    waitEvents(4, 2, 300);
    idle(60);
    checkOutput("b2b_dv_cnt", dvTimes.size(), 4);
    checkOutput("b2b_done_cnt", doneTimes.size(), 2);
    if (dvTimes.size() >= 4) begin
      checkOutput("b2b_b1", dvBytes[1], 8'h01);
      checkOutput("b2b_b2", dvBytes[2], 8'h00);
      checkOutput("b2b_b3", dvBytes[3], 8'h03);
    end

    clearLogs();
    autoEn = 1'b1;
    applyStimulus(16'h00FF);
    waitEvents(6, 3, 400);
    checkOutput("auto_dv_cnt", dvTimes.size(), 6);
    if (dvTimes.size() >= 6) begin
      checkOutput("auto_period", dvTimes[4] - dvTimes[2], REFRESH * 10);
      checkOutput("auto_msb", dvBytes[4], 8'h00);
      checkOutput("auto_lsb", dvBytes[5], 8'hFF);
    end
    waitEvents(7, 3, 200);
    autoEn = 1'b0;
    waitEvents(8, 4, 300);
    idle(250);
    checkOutput("auto_stop_dv", dvTimes.size(), 8);
    checkOutput("auto_stop_done", doneTimes.size(), 4);
    if (dvBytes.size() >= 8) checkOutput("auto_last_lsb", dvBytes[7], 8'hFF);

    clearLogs();
    stuck = 1'b1;
    applyStimulus(16'h4321);
    waitEvents(1, 0, 20);
    checkOutput("to_dv_seen", dvTimes.size(), 1);
    repeat (8) @(negedge clk);
    checkOutput("to_err_pre", err, 1'b0);
    checkOutput("to_busy_pre", busy, 1'b1);
    @(negedge clk);
    checkOutput("to_err", err, 1'b1);
    checkOutput("to_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    idle(30);
    checkOutput("to_no_lsb", dvTimes.size(), 1);
    checkOutput("to_err_sticky", err, 1'b1);
    stuck = 1'b0;
    clearLogs();
    applyStimulus(16'h5678);
    @(negedge clk);
    checkOutput("to_err_clr", err, 1'b0);
    @(posedge clk);
    #1;
    waitEvents(2, 1, 200);
    checkOutput("to_retry_dv", dvTimes.size(), 2);
    if (dvTimes.size() >= 2) begin
      checkOutput("to_retry_msb", dvBytes[0], 8'h56);
      checkOutput("to_retry_lsb", dvBytes[1], 8'h78);
    end

    clearLogs();
    applyStimulus(16'hCAFE);
    waitEvents(2, 0, 100);
    idle(4);
    checkOutput("rmf_busy_pre", busy, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("rmf_byte", txByte, 8'h00);
    checkOutput("rmf_dv", txDv, 1'b0);
    checkOutput("rmf_busy", busy, 1'b0);
    checkOutput("rmf_done", done, 1'b0);
    checkOutput("rmf_err", err, 1'b0);
    idle(2);
    rstN = 1'b1;
    idle(50);
    checkOutput("rmf_no_dv", dvTimes.size(), 2);
    checkOutput("rmf_no_done", doneTimes.size(), 0);

    // Each frame must carry the newest code sampled before its launch edge (one cycle
    // before the MSB pulse), and needs at least one fresh write since the previous launch.
    clearLogs();
    wrTimes.delete();
    wrVals.delete();
    for (int i = 0; i < 40; i++) begin
      spiDelay = $urandom_range(1, 20);
      applyStimulus(16'($urandom));
      idle($urandom_range(0, 40));
    end
    idle(200);
    nFrames = dvTimes.size() / 2;
    checkOutput("rnd_dv_even", dvTimes.size() % 2, 0);
    checkOutput("rnd_done_cnt", doneTimes.size(), nFrames);
    prevLaunch = 0;
    for (int k = 0; k < nFrames; k++) begin
      launch  = dvTimes[2*k] - 5;
      expCode = 16'h0000;
      fresh   = 1'b0;
      foreach (wrTimes[j]) begin
        if (wrTimes[j] <= launch - 10) begin
          expCode = wrVals[j];
          if (wrTimes[j] >= prevLaunch) fresh = 1'b1;
        end
      end
      checkOutput("rnd_msb", dvBytes[2*k], expCode[15:8]);
      checkOutput("rnd_lsb", dvBytes[2*k+1], expCode[7:0]);
      checkOutput("rnd_fresh", fresh, 1'b1);
      prevLaunch = launch;
    end
    checkOutput("rnd_last_sent", (nFrames > 0) && (wrTimes[$] <= prevLaunch - 10), 1'b1);
    checkOutput("dv_while_busy", dvBad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dac_write_sequencer.md
Name: dac_write_sequencer

Overview:
- Upstream of SPI_Master_With_Single_CS on the DAC path.
- Replaces the free-running counter scheduler: accepts a 16-bit DAC code by request/strobe, or by a periodic auto-refresh timer.
- Splits the code into MSB then LSB bytes and hands each to the SPI master using its TX_DV/TX_Ready handshake, with both bytes sent under one CS frame (TX_Count = 2).
- Reports busy, done and handshake-timeout status.

Parameters:
- REFRESH_CYCLES, 50000, auto-refresh period in i_Clk cycles (1 ms at 50 MHz); must be ≥ 4.
- ACK_TIMEOUT, 1023, maximum cycles to wait for i_TX_Ready to drop after an o_TX_DV pulse.

Ports:
- i_Clk  input  1  system clock (CLOCK_50).
- i_Rst_L  input  1  asynchronous active-low reset.
- i_DAC_Val  input  16  DAC code; sampled only when a write is accepted.
- i_DAC_Wr  input  1  single-cycle write request.
- i_Auto_En  input  1  enables periodic re-send of the last code.
- i_TX_Ready  input  1  from SPI master o_TX_Ready.
- o_TX_Byte  output  8  to SPI master i_TX_Byte.
- o_TX_DV  output  1  to SPI master i_TX_DV; single-cycle pulse.
- o_TX_Count  output  2  to SPI master i_TX_Count; constant 2'd2.
- o_Busy  output  1  high while any state other than IDLE is active.
- o_Done  output  1  one-cycle pulse when a two-byte frame completes.
- o_Err  output  1  sticky timeout flag; cleared only by reset or by an accepted i_DAC_Wr.

Behaviour:
- Reset values (asynchronous, while i_Rst_L = 0): o_TX_Byte = 0, o_TX_DV = 0, o_Busy = 0, o_Done = 0, o_Err = 0, state = IDLE, shadow code = 0, pending = 0, refresh counter = 0. o_TX_Count is always 2'd2.
- Shadow register (16 bits) holds the last accepted code.
- i_DAC_Wr sampled high:
  - Loads the shadow register with i_DAC_Val and sets pending.
  - Clears o_Err.
  - Works in any state; the latest write wins.
  - A write arriving mid-frame does not alter bytes already latched for that frame. It causes exactly one extra frame after the current frame's DONE.
- Refresh counter:
  - Counts while i_Auto_En = 1, wraps at REFRESH_CYCLES-1, and sets pending on wrap.
  - Held at 0 while i_Auto_En = 0.
- States:
  - IDLE: if pending and i_TX_Ready = 1, latch the shadow code into the frame register, clear pending, go to SEND_MSB.
  - SEND_MSB: o_TX_Byte = frame[15:8], o_TX_DV = 1 for exactly one cycle, go to ACK_MSB.
  - ACK_MSB: wait for i_TX_Ready = 0, then go to WAIT_MSB. If the timeout counter reaches ACK_TIMEOUT first, set o_Err and go to IDLE.
  - WAIT_MSB: wait for i_TX_Ready = 1, then go to SEND_LSB.
  - SEND_LSB: o_TX_Byte = frame[7:0], o_TX_DV = 1 for one cycle, go to ACK_LSB.
  - ACK_LSB: same as ACK_MSB, with success going to WAIT_LSB.
  - WAIT_LSB: wait for i_TX_Ready = 1, then go to DONE.
  - DONE: o_Done = 1 for one cycle, go to IDLE.
- The timeout counter clears on entry to each ACK state.
- Timing and data rules:
  - o_TX_DV is never asserted while i_TX_Ready = 0.
  - o_TX_Byte holds its value after a DV pulse until the next DV.
  - Latency from i_DAC_Wr (in IDLE, with i_TX_Ready = 1) to the first o_TX_DV is 2 cycles.
- Simultaneous events:
  - A refresh wrap on the same cycle as i_DAC_Wr produces a single pending frame carrying the new code.
  - DONE with pending set returns to IDLE and starts the next frame on the following cycle.
- Reset asserted mid-frame aborts immediately. The SPI master is reset from the same i_Rst_L, so no partial frame survives.

Test Plan:
- Single write: i_DAC_Wr with i_DAC_Val = 16'hA55A and an SPI master model (ready drops 1 cycle after DV, rises 16 cycles later) → DV pulses carrying 8'hA5 then 8'h5A, o_Done one cycle after the second ready rise, o_Busy low afterwards.
- Write during frame: write 16'h1234, then 16'hBEEF during WAIT_MSB → the first frame sends 12/34; a second frame follows immediately and sends BE/EF; o_Done pulses twice.
- Back-to-back writes 16'h0001, 16'h0002, 16'h0003 during one frame → only two frames are sent: 0001 then 0003.
- Auto-refresh: REFRESH_CYCLES = 100, i_Auto_En = 1, one write of 16'h00FF → the frame 00/FF repeats every 100 cycles; setting i_Auto_En = 0 stops it after any frame already in progress.
- Timeout: ACK_TIMEOUT = 8, model holds i_TX_Ready = 1 forever → o_Err set after 8 cycles in ACK_MSB, return to IDLE, no LSB DV; a following write clears o_Err.
- Reset mid-frame: assert i_Rst_L = 0 during WAIT_LSB → all outputs are at reset values in the same cycle; after release there is no DV until a new write.
